// File: rtl/bullet_pool.sv
// Per-player projectile pool: spawns bullets on fire edges subject to a cooldown, then once per
// frame steps each live bullet and resolves its destination tile through a 1-cycle map read port.
module bullet_pool #(
   parameter int N_BUL      = 4,
   parameter int SPEED      = 4,
   parameter int COOLDOWN   = 8,
   parameter int TILE_SHIFT = 5,
   parameter int MAP_W      = 20,
   parameter int MAP_H      = 15,
   parameter int AW         = 9
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 frame_tick,
   input  logic                 fire,
   input  logic [9:0]           tank_x,
   input  logic [9:0]           tank_y,
   input  logic [1:0]           tank_dir,
   output logic [AW-1:0]        map_addr,
   input  logic [2:0]           map_data,
   output logic [N_BUL-1:0]     bul_valid,
   output logic [10*N_BUL-1:0]  bul_x,
   output logic [10*N_BUL-1:0]  bul_y,
   output logic                 wall_break,
   output logic [AW-1:0]        break_addr,
   output logic                 base_hit,
   output logic [2:0]           base_id,
   output logic                 busy,
   output logic                 overrun
);

   localparam int IW = (N_BUL > 1) ? $clog2(N_BUL) : 1;
   localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam logic signed [10:0] SPD  = 11'(SPEED);
   localparam logic signed [10:0] XLIM = 11'(MAP_W << TILE_SHIFT);
   localparam logic signed [10:0] YLIM = 11'(MAP_H << TILE_SHIFT);
   localparam logic [IW-1:0] LAST = IW'(N_BUL - 1);

   typedef enum logic [2:0] {IDLE, SPAWN, ADDR, CHECK, DONE} state_t;

   typedef struct packed {
      logic          oob;
      logic [9:0]    x;
      logic [9:0]    y;
      logic [AW-1:0] addr;
   } step_t;

   state_t         state;
   logic [IW-1:0]  idx;
   logic [IW-1:0]  pidx;
   logic [IW-1:0]  free_idx;
   logic           have_free;
   logic [N_BUL-1:0] skip;
   logic [1:0]     dir [N_BUL];
   logic [CW-1:0]  cooldown;
   logic           fire_q;
   logic           fire_pend;
   logic           fire_edge;
   logic           spawn_req;
   logic           cd_zero;
   logic           live;
   logic           advance;
   logic           preload_ok;
   step_t          cur;
   step_t          pre;

   // One SPEED step along dir in 11-bit signed space so underflow shows up as a negative value.
   function automatic step_t step_of(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
      step_t s;
      logic signed [10:0] sx;
      logic signed [10:0] sy;
      sx = signed'({1'b0, x});
      sy = signed'({1'b0, y});
      case (d)
         2'd0:    sy = sy - SPD;
         2'd1:    sx = sx + SPD;
         2'd2:    sy = sy + SPD;
         default: sx = sx - SPD;
      endcase
      s.oob  = sx[10] || sy[10] || (sx >= XLIM) || (sy >= YLIM);
      s.x    = sx[9:0];
      s.y    = sy[9:0];
      s.addr = AW'((int'(s.y) >> TILE_SHIFT) * MAP_W + (int'(s.x) >> TILE_SHIFT));
      return s;
   endfunction

   always_comb begin
      fire_edge = fire & ~fire_q;
      if (state == SPAWN)   pidx = idx;
      else if (idx == LAST) pidx = '0;
      else                  pidx = idx + IW'(1);
      cur        = step_of(bul_x[10*int'(idx) +: 10], bul_y[10*int'(idx) +: 10], dir[idx]);
      pre        = step_of(bul_x[10*int'(pidx) +: 10], bul_y[10*int'(pidx) +: 10], dir[pidx]);
      live       = bul_valid[idx] && !skip[idx];
      preload_ok = bul_valid[pidx] && !skip[pidx] && !pre.oob;
      advance    = ((state == ADDR) && !(live && !cur.oob)) || (state == CHECK);
      have_free  = 1'b0;
      free_idx   = '0;
      for (int i = N_BUL - 1; i >= 0; i--) begin
         if (!bul_valid[i]) begin
            have_free = 1'b1;
            free_idx  = IW'(i);
         end
      end
   end

   // Event pulses decode map_data during CHECK so the map owner can clear a broken tile
   // before the next slot's read is launched.
   always_comb begin
      wall_break = (state == CHECK) && (map_data == 3'd2);
      base_hit   = (state == CHECK) && ((map_data == 3'd3) || (map_data == 3'd4));
      base_id    = base_hit ? map_data : 3'd0;
      break_addr = wall_break ? map_addr : '0;
   end

   // map_addr is loaded on entry to ADDR(i), so the read launches during ADDR and lands in CHECK.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         idx       <= '0;
         skip      <= '0;
         cooldown  <= '0;
         fire_q    <= 1'b0;
         fire_pend <= 1'b0;
         spawn_req <= 1'b0;
         cd_zero   <= 1'b0;
         map_addr  <= '0;
         bul_valid <= '0;
         bul_x     <= '0;
         bul_y     <= '0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         for (int i = 0; i < N_BUL; i++) dir[i] <= 2'd0;
      end else begin
         fire_q <= fire;
         if (fire_edge) fire_pend <= 1'b1;
         if (frame_tick && (state != IDLE)) overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (frame_tick) begin
                  spawn_req <= fire_pend | fire_edge;
                  cd_zero   <= (cooldown == '0);
                  if (cooldown != '0) cooldown <= cooldown - CW'(1);
                  fire_pend <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SPAWN;
               end
            end
            SPAWN: begin
               if (spawn_req && cd_zero && have_free) begin
                  bul_valid[free_idx]             <= 1'b1;
                  skip[free_idx]                  <= 1'b1;
                  bul_x[10*int'(free_idx) +: 10]  <= tank_x;
                  bul_y[10*int'(free_idx) +: 10]  <= tank_y;
                  dir[free_idx]                   <= tank_dir;
                  cooldown                        <= CW'(COOLDOWN);
               end
               if (preload_ok) map_addr <= pre.addr;
               state <= ADDR;
            end
            ADDR: begin
               if (!advance)  state <= CHECK;
               else if (live) bul_valid[idx] <= 1'b0;
            end
            CHECK: begin
               if (map_data == 3'd0) begin
                  bul_x[10*int'(idx) +: 10] <= cur.x;
                  bul_y[10*int'(idx) +: 10] <= cur.y;
               end else begin
                  bul_valid[idx] <= 1'b0;
               end
            end
            DONE: begin
               skip  <= '0;
               busy  <= 1'b0;
               idx   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (advance) begin
            if (idx == LAST) begin
               state <= DONE;
            end else begin
               idx   <= idx + IW'(1);
               state <= ADDR;
               if (preload_ok) map_addr <= pre.addr;
            end
         end
      end
   end

endmodule
